// File: rtl/snake_matrix_scan_if.sv
// Game-state bus from the snake core and drive bus to the 16x16 LED matrix.
interface snake_matrix_scan_if;
    logic [127:0] Locations_Flat;
    logic [3:0]   Length;
    logic [7:0]   Food;
    logic         Blank;
    logic [15:0]  Row_Sel;
    logic [15:0]  Col_Head;
    logic [15:0]  Col_Body;
    logic [15:0]  Col_Food;
    logic         Frame_Start;

    // Master: game core / stimulus side
    modport master (
        output Locations_Flat, Length, Food, Blank,
        input  Row_Sel, Col_Head, Col_Body, Col_Food, Frame_Start
    );

    // Slave: the matrix scanner
    modport slave (
        input  Locations_Flat, Length, Food, Blank,
        output Row_Sel, Col_Head, Col_Body, Col_Food, Frame_Start
    );
endinterface

// File: rtl/snake_matrix_scan.sv
// Row-multiplexed 16x16 LED matrix scanner for the snake game core.
// Snapshots game state once per frame, builds per-row column bitmaps by
// walking the 16 segment slots, then holds each row lit for DWELL cycles.
module snake_matrix_scan #(
    parameter int unsigned DWELL = 1024
) (
    input  logic                Clk,
    input  logic                Reset_n,
    snake_matrix_scan_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DWELL + 1);

    typedef enum logic [1:0] {IDLE, SNAP, BUILD, SHOW} state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } cell_t;

    state_t             state_q, state_d;
    logic [3:0]         row_q, row_d;
    logic [3:0]         seg_q, seg_d;
    logic [CNT_W-1:0]   dwell_q, dwell_d;
    logic [127:0]       loc_q, loc_d;
    logic [3:0]         len_q, len_d;
    cell_t              food_q, food_d;
    logic [15:0]        head_bm_q, head_bm_d;
    logic [15:0]        body_bm_q, body_bm_d;
    logic [15:0]        food_bm_q, food_bm_d;
    logic [15:0]        row_sel_q, row_sel_d;
    logic [15:0]        col_head_q, col_head_d;
    logic [15:0]        col_body_q, col_body_d;
    logic [15:0]        col_food_q, col_food_d;
    logic               frame_start_q, frame_start_d;
    cell_t              slot;
    logic               drive_row;

    // Next-state, snapshot, bitmap build and output-register input logic
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        seg_d         = seg_q;
        dwell_d       = dwell_q;
        loc_d         = loc_q;
        len_d         = len_q;
        food_d        = food_q;
        head_bm_d     = head_bm_q;
        body_bm_d     = body_bm_q;
        food_bm_d     = food_bm_q;
        frame_start_d = 1'b0;
        row_sel_d     = '0;
        col_head_d    = '0;
        col_body_d    = '0;
        col_food_d    = '0;
        drive_row     = 1'b0;
        // Slot seg lives at bits [127-8*seg -: 8]
        slot          = cell_t'(loc_q[{4'd15 - seg_q, 3'b000} +: 8]);

        unique case (state_q)
            IDLE: begin
                state_d       = SNAP;
                frame_start_d = 1'b1;
            end
            SNAP: begin
                loc_d     = bus.Locations_Flat;
                len_d     = bus.Length;
                food_d    = cell_t'(bus.Food);
                row_d     = '0;
                seg_d     = '0;
                dwell_d   = '0;
                head_bm_d = '0;
                body_bm_d = '0;
                food_bm_d = '0;
                state_d   = BUILD;
            end
            BUILD: begin
                if ((seg_q <= len_q) && (slot.row == row_q)) begin
                    if (seg_q == 4'd0) head_bm_d[slot.col] = 1'b1;
                    else               body_bm_d[slot.col] = 1'b1;
                end
                if ((seg_q == 4'd0) && (food_q.row == row_q)) begin
                    food_bm_d[food_q.col] = 1'b1;
                end
                seg_d = seg_q + 4'd1;
                if (seg_q == 4'd15) begin
                    state_d   = SHOW;
                    dwell_d   = '0;
                    drive_row = 1'b1;
                end
            end
            SHOW: begin
                if (dwell_q == CNT_W'(DWELL - 1)) begin
                    head_bm_d = '0;
                    body_bm_d = '0;
                    food_bm_d = '0;
                    dwell_d   = '0;
                    seg_d     = '0;
                    if (row_q == 4'd15) begin
                        state_d       = SNAP;
                        frame_start_d = 1'b1;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = BUILD;
                    end
                end else begin
                    dwell_d   = dwell_q + CNT_W'(1);
                    drive_row = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Blank only masks the drive; scanning carries on underneath
        if (drive_row && !bus.Blank) begin
            row_sel_d  = 16'd1 << row_q;
            col_head_d = head_bm_d;
            col_body_d = body_bm_d;
            col_food_d = food_bm_d;
        end
    end

    // State, counters, snapshot and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            row_q         <= '0;
            seg_q         <= '0;
            dwell_q       <= '0;
            loc_q         <= '0;
            len_q         <= '0;
            food_q        <= '0;
            head_bm_q     <= '0;
            body_bm_q     <= '0;
            food_bm_q     <= '0;
            row_sel_q     <= '0;
            col_head_q    <= '0;
            col_body_q    <= '0;
            col_food_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            seg_q         <= seg_d;
            dwell_q       <= dwell_d;
            loc_q         <= loc_d;
            len_q         <= len_d;
            food_q        <= food_d;
            head_bm_q     <= head_bm_d;
            body_bm_q     <= body_bm_d;
            food_bm_q     <= food_bm_d;
            row_sel_q     <= row_sel_d;
            col_head_q    <= col_head_d;
            col_body_q    <= col_body_d;
            col_food_q    <= col_food_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.Row_Sel     = row_sel_q;
    assign bus.Col_Head    = col_head_q;
    assign bus.Col_Body    = col_body_q;
    assign bus.Col_Food    = col_food_q;
    assign bus.Frame_Start = frame_start_q;

endmodule

// File: tb/tb_snake_matrix_scan.sv
// Scoreboard bench for snake_matrix_scan: each frame's hand-computed rows are
// queued at Frame_Start; a monitor pops one entry per lit row and compares.
module tb_snake_matrix_scan;

    localparam int unsigned DWELL = 4;
    localparam int unsigned FRAME = 1 + 16 * (16 + DWELL);

    typedef struct packed {
        logic [15:0] row_sel;
        logic [15:0] head;
        logic [15:0] body;
        logic [15:0] food;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    snake_matrix_scan_if bus ();

    snake_matrix_scan #(.DWELL(DWELL)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 Clk = ~Clk;

    exp_t        sb[$];
    exp_t        fr[16];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          fs_cyc = 0;
    bit          fs_valid = 1'b0;
    bit          mon_en = 1'b0;
    logic [15:0] prev_rs = '0;
    int          on_cnt = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Default frame: each row lit with empty columns
    task automatic clear_frame();
        for (int r = 0; r < 16; r++) begin
            fr[r] = '{row_sel: 16'd1 << r, head: 16'h0, body: 16'h0, food: 16'h0};
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < 16; r++) sb.push_back(fr[r]);
    endtask

    task automatic set_in(input logic [127:0] loc, input logic [3:0] len, input logic [7:0] food);
        bus.Locations_Flat = loc;
        bus.Length         = len;
        bus.Food           = food;
    endtask

    task automatic wait_fs();
        for (int i = 0; i < int'(FRAME) + 10; i++) begin
            @(negedge Clk);
            if (bus.Frame_Start) return;
        end
        checks++;
        failures++;
        $display("FAIL fs_timeout: no Frame_Start within %0d cycles", FRAME + 10);
    endtask

    task automatic wait_row(input logic [15:0] rs);
        for (int i = 0; i < int'(FRAME) + 10; i++) begin
            @(negedge Clk);
            if (bus.Row_Sel == rs) return;
        end
        checks++;
        failures++;
        $display("FAIL row_timeout: Row_Sel never reached %h", rs);
    endtask

    // Row monitor: pop/compare on each row turn-on, check dwell on turn-off
    always @(negedge Clk) begin
        exp_t e;
        if (mon_en && bus.Row_Sel != 16'h0 && prev_rs == 16'h0) begin
            on_cnt = 1;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: row %h lit with nothing expected", bus.Row_Sel);
            end else begin
                e = sb.pop_front();
                check("row_cols", {bus.Row_Sel, bus.Col_Head, bus.Col_Body, bus.Col_Food}, e);
            end
            if (bus.Row_Sel == 16'h0001) check("first_row_latency", 64'(cyc - fs_cyc), 64'd17);
        end else if (bus.Row_Sel != 16'h0) begin
            on_cnt++;
        end else if (mon_en && prev_rs != 16'h0) begin
            check("dwell_len", 64'(on_cnt), 64'(DWELL));
        end
        prev_rs = bus.Row_Sel;
    end

    // Frame_Start monitor: period between pulses
    always @(negedge Clk) begin
        if (bus.Frame_Start) begin
            if (fs_valid) check("frame_period", 64'(cyc - fs_cyc), 64'(FRAME));
            fs_cyc   = cyc;
            fs_valid = 1'b1;
        end
    end

    initial begin
        logic [127:0] loc;
        int           nz;

        bus.Locations_Flat = '0;
        bus.Length         = '0;
        bus.Food           = '0;
        bus.Blank          = 1'b0;

        repeat (3) @(negedge Clk);
        check("reset_cols", {bus.Row_Sel, bus.Col_Head, bus.Col_Body, bus.Col_Food}, 64'h0);
        check("reset_fs", 64'(bus.Frame_Start), 64'h0);
        Reset_n = 1'b1;

        // F0: all-zero inputs -> head and food at (0,0)
        @(negedge Clk);
        check("fs_after_reset", 64'(bus.Frame_Start), 64'h1);
        mon_en = 1'b1;
        clear_frame();
        fr[0].head = 16'h0001;
        fr[0].food = 16'h0001;
        push_frame();

        // F1: head/body on row 7, food at row 3 col 0
        wait_fs();
        set_in({8'h7D, 8'h7C, 8'h7B, 104'h0}, 4'd2, 8'h30);
        clear_frame();
        fr[7].head = 16'h2000;
        fr[7].body = 16'h1800;
        fr[3].food = 16'h0001;
        push_frame();

        // F2: Length=0 ignores slot 1
        wait_fs();
        set_in({8'h7D, 8'h7C, 112'h0}, 4'd0, 8'hF5);
        clear_frame();
        fr[7].head  = 16'h2000;
        fr[15].food = 16'h0020;
        push_frame();

        // F3: Length=15, head/body/food overlap, duplicate slot
        wait_fs();
        loc = '0;
        loc[127 -: 8] = 8'h7D;
        loc[119 -: 8] = 8'h7D;
        for (int k = 2; k < 15; k++) loc[127 - 8 * k -: 8] = {4'hA, 4'(k)};
        loc[7 -: 8] = 8'hA2;
        set_in(loc, 4'd15, 8'h7D);
        clear_frame();
        fr[7].head  = 16'h2000;
        fr[7].body  = 16'h2000;
        fr[7].food  = 16'h2000;
        fr[10].body = 16'h7FFC;
        push_frame();

        // F4: inputs change during row 3; frame keeps the snapshot
        wait_fs();
        set_in({8'h32, 8'hC4, 112'h0}, 4'd1, 8'h00);
        clear_frame();
        fr[0].food  = 16'h0001;
        fr[3].head  = 16'h0004;
        fr[12].body = 16'h0010;
        push_frame();
        wait_row(16'h0008);
        bus.Locations_Flat = {8'h99, 8'hC8, 112'h0};

        // F5: new values take effect
        wait_fs();
        clear_frame();
        fr[0].food  = 16'h0001;
        fr[9].head  = 16'h0200;
        fr[12].body = 16'h0100;
        push_frame();

        // F6: Blank during row 0 SHOW, held for the rest of the frame
        wait_fs();
        mon_en = 1'b0;
        wait_row(16'h0001);
        bus.Blank = 1'b1;
        @(negedge Clk);
        check("blank_next_edge", {bus.Row_Sel, bus.Col_Head, bus.Col_Body, bus.Col_Food}, 64'h0);
        nz = 0;
        for (int i = 0; i < int'(FRAME) + 10; i++) begin
            @(negedge Clk);
            if (bus.Row_Sel != 16'h0) nz++;
            if (bus.Frame_Start) break;
        end
        check("blank_rows_dark", 64'(nz), 64'h0);
        check("blank_fs_seen", 64'(bus.Frame_Start), 64'h1);
        bus.Blank = 1'b0;

        // F7: scanning resumes with the same snapshot content as F5
        mon_en = 1'b1;
        push_frame();

        // F8: mid-frame reset during row 9
        wait_fs();
        mon_en = 1'b0;
        wait_row(16'h0200);
        Reset_n = 1'b0;
        #1;
        check("async_reset_cols", {bus.Row_Sel, bus.Col_Head, bus.Col_Body, bus.Col_Food}, 64'h0);
        check("async_reset_fs", 64'(bus.Frame_Start), 64'h0);
        fs_valid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        check("fs_after_midreset", 64'(bus.Frame_Start), 64'h1);
        set_in({8'h7D, 8'h7C, 8'h7B, 104'h0}, 4'd2, 8'h30);
        clear_frame();
        fr[7].head = 16'h2000;
        fr[7].body = 16'h1800;
        fr[3].food = 16'h0001;
        mon_en = 1'b1;
        push_frame();

        wait_fs();
        check("sb_drained", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
